// File: rtl/barcode_rx.sv
`default_nettype none
// ============================================================================
// Module      : barcode_rx
// Description : Serial barcode receiver. It measures the low time of the start
//               bit as period P. It then samples each following data bit P
//               cycles after its falling edge, which gives 8 bits, MSB first.
//               An ID is published only when its top two bits are 00.
// Revision    : 1.0 - initial release
// ============================================================================
module barcode_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_START     = 2'd1;
  localparam logic [1:0]  S_WAIT_FALL = 2'd2;
  localparam logic [1:0]  S_SAMPLE    = 2'd3;
  localparam logic [21:0] C_TMR_MAX   = 22'h3FFFFF;

  logic        r_bc_ff1;
  logic        r_bc_ff2;
  logic        r_bc_ff3;
  logic [1:0]  r_state;
  logic [21:0] r_timer;
  logic [21:0] r_period;
  logic [21:0] r_smp_timer;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;

  logic        w_bc_s;
  logic        w_fall;
  logic        w_sample;
  logic        w_frame_done;
  logic        w_id_ok;
  logic [7:0]  w_shift_nxt;
  logic [3:0]  w_bit_cnt_nxt;

  // Two-flop synchronizer plus a third flop that holds the previous value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bc_ff1 <= 1'b1;
      r_bc_ff2 <= 1'b1;
      r_bc_ff3 <= 1'b1;
    end else begin
      r_bc_ff1 <= BC;
      r_bc_ff2 <= r_bc_ff1;
      r_bc_ff3 <= r_bc_ff2;
    end
  end

  assign w_bc_s        = r_bc_ff2;
  assign w_fall        = r_bc_ff3 & ~r_bc_ff2;
  assign w_sample      = (r_state == S_SAMPLE) && (r_smp_timer == r_period);
  assign w_shift_nxt   = {r_shift[6:0], w_bc_s};
  assign w_bit_cnt_nxt = r_bit_cnt + 4'd1;
  assign w_frame_done  = w_sample && (w_bit_cnt_nxt >= 4'd8);
  assign w_id_ok       = (w_shift_nxt[7:6] == 2'b00);

  // Frame FSM: measure the start bit, then sample each data bit at P cycles after its falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= 22'd0;
      r_period    <= 22'd0;
      r_smp_timer <= 22'd0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_timer   <= 22'd0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (!w_bc_s) begin
            // Saturate rather than wrap so a stuck-low line never yields a short P
            if (r_timer != C_TMR_MAX) begin
              r_timer <= r_timer + 22'd1;
            end
          end else begin
            r_period <= r_timer;
            // A zero-length start bit carries no timing reference, so drop the frame
            r_state  <= (r_timer == 22'd0) ? S_IDLE : S_WAIT_FALL;
          end
        end
        S_WAIT_FALL: begin
          if (w_fall) begin
            r_smp_timer <= 22'd0;
            r_state     <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          // Edges before the sample point are ignored; only the timer matters here
          if (w_sample) begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_state   <= (w_bit_cnt_nxt < 4'd8) ? S_WAIT_FALL : S_IDLE;
          end else begin
            r_smp_timer <= r_smp_timer + 22'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Publish the ID only on a completed frame whose top two bits are 00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID <= 8'h00;
    end else if (w_frame_done && w_id_ok) begin
      ID <= w_shift_nxt;
    end
  end

  // Valid flag: a new valid frame sets it and takes priority over the consumer's clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_vld <= 1'b0;
    end else if (w_frame_done && w_id_ok) begin
      ID_vld <= 1'b1;
    end else if (clr_ID_vld) begin
      ID_vld <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_barcode_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_barcode_rx
// Description : Self-checking bench for barcode_rx. It drives barcode frames
//               built from pulse lengths. For each frame it works out the
//               decoded value and the completion cycle from the
//               pulse-length/period rule, and it compares ID/ID_vld on every
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barcode_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BC;
  logic       clr_ID_vld = 1'b0;
  logic [7:0] ID;
  logic       ID_vld;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [7:0] exp_id = 8'h00;
  logic       exp_vld = 1'b0;
  int         pend_cyc = -1;
  logic [7:0] pend_id = 8'h00;
  bit         pend_ok = 1'b0;
  int         force_clr_cyc = -1;
  bit         rnd_clr = 1'b0;
  bit         chk_en = 1'b0;

  barcode_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld)
  );

  always #5 clk = ~clk;

  // Reference model: applies the scheduled frame completion, or the consumer clear, at each edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      exp_id   = 8'h00;
      exp_vld  = 1'b0;
      pend_cyc = -1;
    end else if ((cyc == pend_cyc) && pend_ok) begin
      exp_id  = pend_id;
      exp_vld = 1'b1;
    end else if (clr_ID_vld) begin
      exp_vld = 1'b0;
    end
  end

  // Consumer acknowledge: occasional random pulses plus one forced at a chosen edge
  always @(negedge clk) begin
    clr_ID_vld = (rnd_clr && ($urandom_range(0, 31) == 0)) || (force_clr_cyc == cyc + 1);
  end

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      checks++;
      if ((ID !== exp_id) || (ID_vld !== exp_vld)) begin
        errors++;
        $display("FAIL model_cmp cyc %0d: ID=%h ID_vld=%b expected ID=%h ID_vld=%b",
                 cyc, ID, ID_vld, exp_id, exp_vld);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] id_req, input logic vld_req,
                           input bit pin_model);
    checks++;
    if ((ID !== id_req) || (ID_vld !== vld_req)) begin
      errors++;
      $display("FAIL %s: ID=%h ID_vld=%b required ID=%h ID_vld=%b", name, ID, ID_vld, id_req, vld_req);
    end
    if (pin_model) begin
      checks++;
      if ((exp_id !== id_req) || (exp_vld !== vld_req)) begin
        errors++;
        $display("FAIL %s_model: model ID=%h ID_vld=%b required ID=%h ID_vld=%b",
                 name, exp_id, exp_vld, id_req, vld_req);
      end
    end
  endtask

  task automatic drive(input int lo, input int hi);
    for (int i = 0; i < lo; i++) begin
      @(negedge clk);
      BC = 1'b0;
    end
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      BC = 1'b1;
    end
  endtask

  // l0: start low cycles, sp: whole start-bit cycles, sh/lg: low cycles for 1/0, per: bit period
  task automatic send_frame(input int l0, input int sp, input logic [7:0] data, input int sh,
                            input int lg, input int per, input int nbits, input bit clr_at_done);
    int         p;
    int         lo;
    logic [7:0] dec;
    p   = l0 - 1;
    dec = 8'h00;
    drive(l0, sp - l0);
    for (int b = 0; b < nbits; b++) begin
      lo  = data[7-b] ? sh : lg;
      dec = {dec[6:0], (lo <= p + 1) ? 1'b1 : 1'b0};
      @(negedge clk);
      BC = 1'b0;
      if ((b == 7) && (p > 0)) begin
        // Sync (2) + edge detect (1) + P sample count + 1 register edge
        pend_cyc = cyc + 4 + p;
        pend_id  = dec;
        pend_ok  = (dec[7:6] == 2'b00);
        if (clr_at_done) force_clr_cyc = pend_cyc;
      end
      drive(lo - 1, per - lo);
    end
  endtask

  initial begin
    int         l0;
    int         sh;
    int         lg;
    int         per;
    int         sp;
    logic [7:0] data;

    rst_n = 1'b0;
    BC    = 1'b1;
    repeat (3) @(posedge clk);
    #3 check_lit("reset_state", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    repeat (1000) @(posedge clk);
    #3 check_lit("idle_1000", 8'h00, 1'b0, 1'b1);

    send_frame(512, 1024, 8'h2A, 256, 768, 1024, 8, 1'b0);
    repeat (20) @(posedge clk);
    #3 check_lit("frame_2A", 8'h2A, 1'b1, 1'b1);

    send_frame(512, 1024, 8'hC5, 256, 768, 1024, 8, 1'b0);
    repeat (20) @(posedge clk);
    #3 check_lit("frame_C5_discard", 8'h2A, 1'b1, 1'b1);

    @(posedge clk);
    #3 force_clr_cyc = cyc + 1;
    @(posedge clk);
    #3 check_lit("clr_pulse", 8'h2A, 1'b0, 1'b1);

    send_frame(512, 1024, 8'h15, 256, 768, 1024, 8, 1'b1);
    repeat (20) @(posedge clk);
    #3 check_lit("set_beats_clr", 8'h15, 1'b1, 1'b1);

    drive(1, 60);
    #3 check_lit("abort_p0", 8'h15, 1'b1, 1'b0);

    rnd_clr = 1'b1;
    for (int f = 0; f < 20; f++) begin
      l0   = $urandom_range(4, 48);
      sh   = $urandom_range(1, l0);
      lg   = $urandom_range(l0 + 1, 2 * l0);
      per  = lg + $urandom_range(2, 12);
      sp   = l0 + $urandom_range(1, 20);
      data = 8'($urandom);
      if ($urandom_range(0, 1) == 1) data[7:6] = 2'b00;
      send_frame(l0, sp, data, sh, lg, per, 8, 1'b0);
      drive(0, 20);
    end
    rnd_clr = 1'b0;
    drive(0, 5);

    send_frame(20, 40, 8'h3C, 8, 30, 40, 4, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 check_lit("reset_mid_frame", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(0, 20);
    send_frame(20, 40, 8'h07, 8, 30, 40, 8, 1'b0);
    repeat (20) @(posedge clk);
    #3 check_lit("frame_07_after_reset", 8'h07, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/barcode_rx.md
BARCODE_RX -- requirements
Module: barcode_rx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port BC, input, 1, serial barcode line, asynchronous to clk, idle high.
REQ-004 SHALL have port clr_ID_vld, input, 1, consumer acknowledge; clears ID_vld.
REQ-005 SHALL have port ID, output, 8, last accepted station ID, MSB first on the wire.
REQ-006 SHALL have port ID_vld, output, 1, high while an unconsumed valid ID is held in ID.

Function
REQ-007 SHALL pass BC through two flops before any use; the edge detector SHALL use a third flop; falling edge = previous 1, current 0.
REQ-008 SHALL count the start-bit low time in a 22-bit timer running at one increment per clk.
REQ-009 SHALL saturate the timer at 22'h3FFFFF and never wrap.
REQ-010 SHALL implement states IDLE, START, WAIT_FALL, SAMPLE.
REQ-011 IDLE: on a synchronized falling edge of BC, clear the timer, clear the bit counter and go to START.
REQ-012 START: increment the timer while synchronized BC is 0; on synchronized BC = 1, freeze the count as period P and go to WAIT_FALL.
REQ-013 WAIT_FALL: on a falling edge, clear the sample timer and go to SAMPLE.
REQ-014 SAMPLE: when the sample timer equals P, shift synchronized BC into the ID shift register at the LSB (first bit ends up in bit 7) and increment the 4-bit bit counter.
REQ-015 SAMPLE exit: go to WAIT_FALL if the bit counter is below 8 after the shift, otherwise go to IDLE.
REQ-016 Bit decoding: a data 1 is a short low pulse (high at P); a data 0 is a long low pulse (low at P).
REQ-017 SHALL update the ID output only on frame completion (8th sample); intermediate shifts SHALL NOT be visible on ID.
REQ-018 On frame completion with ID[7:6] == 2'b00, ID SHALL load the shifted value and ID_vld SHALL set on the same edge.
REQ-019 On frame completion with ID[7:6] != 2'b00, the frame SHALL be discarded; ID and ID_vld SHALL be unchanged.
REQ-020 Latency: ID_vld SHALL rise on the clk edge after the 8th sample point, i.e. P+1 cycles after the 8th synchronized falling edge.
REQ-021 ID_vld SHALL clear on the clk edge after clr_ID_vld is sampled high.
REQ-022 If a valid-ID completion and clr_ID_vld occur in the same cycle, set SHALL win (ID_vld = 1, new ID).
REQ-023 A new valid frame while ID_vld = 1 SHALL overwrite ID; ID_vld SHALL stay 1.
REQ-024 If P = 0 (start bit shorter than synchronizer resolution), the frame SHALL be aborted and the FSM SHALL return to IDLE.
REQ-025 Falling edges during SAMPLE before the sample point SHALL be ignored.
REQ-026 No timeout after START: a stalled line SHALL hold the FSM in WAIT_FALL indefinitely.

Reset
REQ-027 On rst_n low, FSM -> IDLE, ID = 8'h00, ID_vld = 0, timers and bit counter = 0, all synchronizer flops = 1, regardless of any mid-frame activity.
REQ-028 On rst_n release mid-frame, the FSM SHALL wait in IDLE for the next falling edge; it SHALL NOT resynchronize into the interrupted frame.

Verification
REQ-029 Reset with BC = 1 -> ID = 8'h00, ID_vld = 0; no state change while BC stays high for 1000 cycles.
REQ-030 Frame with start low for 512 cycles, data 8'h2A (short pulse 256, long pulse 768, bit period 1024) -> ID = 8'h2A, ID_vld = 1 about 513 cycles after the 8th falling edge.
REQ-031 Frame with data 8'hC5, same timing -> ID and ID_vld unchanged from their prior values.
REQ-032 With ID_vld = 1, pulse clr_ID_vld for 1 cycle -> ID_vld = 0 next edge; ID holds its value.
REQ-033 Assert clr_ID_vld in exactly the completion cycle of frame 8'h15 -> ID_vld = 1, ID = 8'h15.
REQ-034 Assert rst_n low after 4 bits of a frame, release, then send frame 8'h07 -> only 8'h07 is reported, ID_vld = 1.
